// File: rtl/pwm_ctrl.sv
// pwm_ctrl: 4-channel PWM scheduler with shadowed duties committed at period boundaries.
// Build option PWM_RAMP_EN: each wrap commit moves active duty toward shadow by at most RAMP_STEP.
module pwm_ctrl #(
   parameter int NCH       = 4,
   parameter int CNT_W     = 8,
   parameter int RAMP_STEP = 1
) (
   input  logic             pwm_clk,
   input  logic             pwm_rst,
   input  logic             cfg_we,
   input  logic             cfg_re,
   input  logic [2:0]       cfg_addr,
   input  logic [31:0]      cfg_wdata,
   output logic [31:0]      cfg_rdata,
   output logic [NCH-1:0]   pwm_o,
   output logic             period_tick,
   output logic             irq
);
   localparam int DW = CNT_W + 1;
   localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);
   logic [CNT_W-1:0] cnt;
   logic             gen, ie, done;
   logic [NCH-1:0]   ch_en;
   logic [DW-1:0]    shadow [NCH];
   logic [DW-1:0]    active [NCH];
   logic             ctrl_wr, stat_wr, gen_rise, unused_ok;
   logic [31:0]      rd_mux;

   assign period_tick = gen & (cnt == {CNT_W{1'b1}});
   assign irq         = done & ie;
   assign ctrl_wr     = cfg_we & (cfg_addr == 3'd0);
   assign stat_wr     = cfg_we & (cfg_addr == 3'd7);
   assign gen_rise    = ctrl_wr & cfg_wdata[0] & ~gen;
   assign unused_ok   = ^{cfg_wdata[31:DW], STEP};

   function automatic logic [DW-1:0] next_duty(input logic [DW-1:0] a, input logic [DW-1:0] s);
`ifdef PWM_RAMP_EN
      return (a < s) ? ((s - a > STEP) ? a + STEP : s) : ((a - s > STEP) ? a - STEP : s);
`else
      return s;
`endif
   endfunction

   always_comb begin
      rd_mux = '0;
      if (cfg_addr == 3'd0) rd_mux = 32'({ie, ch_en, gen});
      if (cfg_addr == 3'd7) rd_mux = 32'(done);
      for (int i = 0; i < NCH; i++)
         if (cfg_addr == 3'(i + 1)) rd_mux = 32'(shadow[i]);
   end

   // Commits read the pre-edge shadow, so a DUTY write landing on a commit edge waits a period.
   always_ff @(posedge pwm_clk or negedge pwm_rst) begin
      if (!pwm_rst) begin
         cnt       <= '0;
         gen       <= 1'b0;
         ch_en     <= '0;
         ie        <= 1'b0;
         done      <= 1'b0;
         pwm_o     <= '0;
         cfg_rdata <= '0;
         for (int i = 0; i < NCH; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         cnt <= gen ? cnt + 1'b1 : '0;
         if (ctrl_wr) {ie, ch_en, gen} <= cfg_wdata[NCH+1:0];
         if (period_tick) done <= 1'b1;
         else if (stat_wr && cfg_wdata[0]) done <= 1'b0;
         if (cfg_re) cfg_rdata <= rd_mux;
         for (int i = 0; i < NCH; i++) begin
            if (cfg_we && cfg_addr == 3'(i + 1)) shadow[i] <= cfg_wdata[DW-1:0];
            if (gen_rise) active[i] <= shadow[i];
            else if (period_tick) active[i] <= next_duty(active[i], shadow[i]);
            pwm_o[i] <= gen & ch_en[i] & ({1'b0, cnt} < active[i]);
         end
      end
   end
endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl: scoreboard bench for pwm_ctrl; expected reads and per-period high counts are queued then compared.
module tb_pwm_ctrl;
   logic        pwm_clk = 1'b0;
   logic        pwm_rst = 1'b0;
   logic        cfg_we = 1'b0, cfg_re = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic [31:0] cfg_rdata;
   logic [3:0]  pwm_o;
   logic        period_tick, irq;
   int          nchk = 0, nfail = 0;
   int          exp_q[$];
   int          hc[6][4];

   always #5 pwm_clk = ~pwm_clk;

   pwm_ctrl dut (
      .pwm_clk(pwm_clk), .pwm_rst(pwm_rst), .cfg_we(cfg_we), .cfg_re(cfg_re),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
      .pwm_o(pwm_o), .period_tick(period_tick), .irq(irq)
   );

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge pwm_clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge pwm_clk);
      cfg_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      @(negedge pwm_clk);
      cfg_re = 1'b1; cfg_addr = a;
      @(negedge pwm_clk);
      cfg_re = 1'b0;
      d = cfg_rdata;
   endtask

   task automatic wait_tick();
      for (int k = 0; k < 600; k++) begin
         @(negedge pwm_clk);
         if (period_tick) return;
      end
      nchk++; nfail++;
      $display("FAIL wait_tick: no period_tick within 600 cycles");
   endtask

   // Counts pwm_o high cycles per 256-cycle period starting at the cnt=0 output; optional write at sample wi (cnt=wi+1).
   task automatic measure(input int nper, input int wi, input logic [2:0] wa, input logic [31:0] wd);
      wait_tick();
      repeat (2) @(negedge pwm_clk);
      for (int p = 0; p < 6; p++) for (int c = 0; c < 4; c++) hc[p][c] = 0;
      for (int i = 0; i < nper * 256; i++) begin
         for (int c = 0; c < 4; c++) hc[i / 256][c] += int'(pwm_o[c]);
         if (i == wi) begin cfg_we = 1'b1; cfg_addr = wa; cfg_wdata = wd; end
         if (i == wi + 1) cfg_we = 1'b0;
         @(negedge pwm_clk);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int x;
      repeat (3) @(negedge pwm_clk);
      nchk++;
      if (pwm_o !== 4'b0 || irq !== 1'b0 || period_tick !== 1'b0 || cfg_rdata !== 32'd0) begin
         nfail++;
         $display("FAIL reset_outputs: pwm_o=%b irq=%b tick=%b rdata=%h, expected all 0", pwm_o, irq, period_tick, cfg_rdata);
      end
      pwm_rst = 1'b1;
      foreach (exp_q[i]) exp_q.delete();
      for (int a = 0; a < 8; a++) begin
         exp_q.push_back(0);
         rd(3'(a), d);
         x = exp_q.pop_front();
         nchk++;
         if (d !== 32'(x)) begin nfail++; $display("FAIL reset_reg%0d: got %h expected %h", a, d, x); end
      end
   endtask

   task automatic test_duty_levels();
      logic [31:0] d;
      int x;
      wr(1, 0); wr(2, 64); wr(3, 128); wr(4, 300);
      exp_q.push_back(300);
      rd(4, d);
      x = exp_q.pop_front();
      nchk++;
      if (d !== 32'(x)) begin nfail++; $display("FAIL duty4_readback: got %0d expected %0d", d, x); end
      wr(0, 32'h1F);
      exp_q.push_back(0); exp_q.push_back(64); exp_q.push_back(128); exp_q.push_back(256);
      measure(1, -5, 0, 0);
      for (int c = 0; c < 4; c++) begin
         x = exp_q.pop_front();
         nchk++;
         if (hc[0][c] !== x) begin nfail++; $display("FAIL duty_ch%0d: high=%0d expected %0d", c, hc[0][c], x); end
      end
   endtask

   task automatic test_commit_timing();
      int x;
      // Duty steps of 1 keep these expectations valid with or without ramping.
      exp_q.push_back(64); exp_q.push_back(63);
      measure(2, 99, 2, 63);
      for (int p = 0; p < 2; p++) begin
         x = exp_q.pop_front();
         nchk++;
         if (hc[p][1] !== x) begin nfail++; $display("FAIL commit_mid p%0d: high=%0d expected %0d", p, hc[p][1], x); end
      end
      exp_q.push_back(63); exp_q.push_back(63); exp_q.push_back(62);
      measure(3, 254, 2, 62);
      for (int p = 0; p < 3; p++) begin
         x = exp_q.pop_front();
         nchk++;
         if (hc[p][1] !== x) begin nfail++; $display("FAIL commit_at_wrap p%0d: high=%0d expected %0d", p, hc[p][1], x); end
      end
   endtask

   task automatic test_channel_mask();
      int x;
      wr(0, 32'h1B);
      wr(2, 128);
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(128); exp_q.push_back(256);
      measure(1, -5, 0, 0);
      for (int c = 0; c < 4; c++) begin
         x = exp_q.pop_front();
         nchk++;
         if (hc[0][c] !== x) begin nfail++; $display("FAIL mask_ch%0d: high=%0d expected %0d", c, hc[0][c], x); end
      end
   endtask

   task automatic test_status_irq();
      logic [31:0] d;
      int x;
      wr(0, 32'h3F);
      wait_tick();
      wr(7, 1);
      nchk++;
      if (irq !== 1'b0) begin nfail++; $display("FAIL irq_clear: irq=%b expected 0", irq); end
      wait_tick();
      nchk++;
      if (irq !== 1'b0) begin nfail++; $display("FAIL irq_on_tick: irq=%b expected 0", irq); end
      cfg_we = 1'b1; cfg_addr = 3'd7; cfg_wdata = 32'd1;
      @(negedge pwm_clk);
      cfg_we = 1'b0;
      nchk++;
      if (irq !== 1'b1) begin nfail++; $display("FAIL irq_set_wins: irq=%b expected 1", irq); end
      exp_q.push_back(1);
      rd(7, d);
      x = exp_q.pop_front();
      nchk++;
      if (d !== 32'(x)) begin nfail++; $display("FAIL status_set: got %0d expected %0d", d, x); end
      wr(7, 1);
      nchk++;
      if (irq !== 1'b0) begin nfail++; $display("FAIL irq_clear2: irq=%b expected 0", irq); end
      exp_q.push_back(0);
      rd(7, d);
      x = exp_q.pop_front();
      nchk++;
      if (d !== 32'(x)) begin nfail++; $display("FAIL status_clear: got %0d expected %0d", d, x); end
      wr(0, 32'h1F);
      wait_tick();
      @(negedge pwm_clk);
      nchk++;
      if (irq !== 1'b0) begin nfail++; $display("FAIL irq_ie_off: irq=%b expected 0", irq); end
      exp_q.push_back(1);
      rd(7, d);
      x = exp_q.pop_front();
      nchk++;
      if (d !== 32'(x)) begin nfail++; $display("FAIL status_ie_off: got %0d expected %0d", d, x); end
   endtask

   task automatic test_ramp();
      int x;
`ifdef PWM_RAMP_EN
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(4);
`else
      exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(4);
      exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(4);
`endif
      measure(6, 10, 1, 4);
      for (int p = 0; p < 6; p++) begin
         x = exp_q.pop_front();
         nchk++;
         if (hc[p][0] !== x) begin nfail++; $display("FAIL ramp p%0d: high=%0d expected %0d", p, hc[p][0], x); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int x;
      exp_q.push_back(128);
      @(negedge pwm_clk);
      cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 3'd3; cfg_wdata = 32'd77;
      @(negedge pwm_clk);
      cfg_we = 1'b0; cfg_re = 1'b0;
      x = exp_q.pop_front();
      nchk++;
      if (cfg_rdata !== 32'(x)) begin nfail++; $display("FAIL rw_same_cycle: got %0d expected %0d", cfg_rdata, x); end
      repeat (3) @(negedge pwm_clk);
      nchk++;
      if (cfg_rdata !== 32'(x)) begin nfail++; $display("FAIL rdata_hold: got %0d expected %0d", cfg_rdata, x); end
      exp_q.push_back(77);
      rd(3, d);
      x = exp_q.pop_front();
      nchk++;
      if (d !== 32'(x)) begin nfail++; $display("FAIL rw_new_value: got %0d expected %0d", d, x); end
      wr(4, 32'hFFFF_F1FF);
      exp_q.push_back(32'h1FF);
      rd(4, d);
      x = exp_q.pop_front();
      nchk++;
      if (d !== 32'(x)) begin nfail++; $display("FAIL duty_width: got %h expected %h", d, x); end
      wr(5, 123);
      for (int a = 5; a < 7; a++) begin
         exp_q.push_back(0);
         rd(3'(a), d);
         x = exp_q.pop_front();
         nchk++;
         if (d !== 32'(x)) begin nfail++; $display("FAIL unmapped%0d: got %0d expected %0d", a, d, x); end
      end
   endtask

   task automatic test_reset_mid_period();
      logic [31:0] d;
      int x;
      int bad;
      wr(0, 32'h3F);
      exp_q.push_back(32'h3F);
      rd(0, d);
      x = exp_q.pop_front();
      nchk++;
      if (d !== 32'(x)) begin nfail++; $display("FAIL ctrl_read: got %h expected %h", d, x); end
      wait_tick();
      repeat (78) @(negedge pwm_clk);
      nchk++;
      if (pwm_o[3] !== 1'b1 || irq !== 1'b1) begin
         nfail++; $display("FAIL pre_reset: pwm_o3=%b irq=%b expected 1 1", pwm_o[3], irq);
      end
      #1 pwm_rst = 1'b0;
      #1;
      nchk++;
      if (pwm_o !== 4'b0 || irq !== 1'b0 || period_tick !== 1'b0 || cfg_rdata !== 32'd0) begin
         nfail++;
         $display("FAIL async_reset: pwm_o=%b irq=%b tick=%b rdata=%h expected all 0", pwm_o, irq, period_tick, cfg_rdata);
      end
      @(negedge pwm_clk);
      pwm_rst = 1'b1;
      for (int a = 0; a < 5; a += 4) begin
         exp_q.push_back(0);
         rd(3'(a), d);
         x = exp_q.pop_front();
         nchk++;
         if (d !== 32'(x)) begin nfail++; $display("FAIL post_reset_reg%0d: got %0d expected %0d", a, d, x); end
      end
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge pwm_clk);
         if (pwm_o !== 4'b0 || period_tick !== 1'b0) bad++;
      end
      nchk++;
      if (bad !== 0) begin nfail++; $display("FAIL post_reset_idle: %0d active cycles expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_duty_levels();
      test_commit_timing();
      test_channel_mask();
      test_status_irq();
      test_ramp();
      test_back_to_back();
      test_reset_mid_period();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
